// File: rtl/turbo_frame_serializer.sv
// Turbo frame serializer: sends sync word, systematic byte, parity byte and
// an even-parity check bit MSB-first. A one-entry holding buffer lets the
// next word be accepted mid-frame so frames can run back-to-back.
module turbo_frame_serializer #(
  parameter logic [7:0]  SYNC_WORD  = 8'hA5,
  parameter int unsigned FRAME_BITS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] sys_in,
  input  logic [7:0] par_in,
  output logic       ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // Frame length is fixed by the 8+8+8+1 layout; reject any other value.
  if (FRAME_BITS != 32'd25) begin : g_bad_frame_bits
    $error("turbo_frame_serializer: FRAME_BITS must be 25");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_SYS  = 3'd2,
    S_PAR  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   sys_q, sys_d;
  logic [BYTE_W-1:0]   par_q, par_d;
  logic                buf_full_q, buf_full_d;
  logic [BYTE_W-1:0]   buf_sys_q, buf_sys_d;
  logic [BYTE_W-1:0]   buf_par_q, buf_par_d;

  logic                ser_out_d;
  logic                ser_valid_d;
  logic                frame_start_d;
  logic                frame_done_d;
  logic                ready_d;
  logic [BYTE_W-1:0]   frame_count_d;

  logic                accept;

  assign accept = load & ena & ready;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sys_q       <= '0;
      par_q       <= '0;
      buf_full_q  <= 1'b0;
      buf_sys_q   <= '0;
      buf_par_q   <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      ready       <= 1'b1;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_q       <= sys_d;
      par_q       <= par_d;
      buf_full_q  <= buf_full_d;
      buf_sys_q   <= buf_sys_d;
      buf_par_q   <= buf_par_d;
      ser_out     <= ser_out_d;
      ser_valid   <= ser_valid_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
      ready       <= ready_d;
      frame_count <= frame_count_d;
    end
  end

  // Next-state: walk the frame fields, fill/drain the holding buffer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sys_d      = sys_q;
    par_d      = par_q;
    buf_full_d = buf_full_q;
    buf_sys_d  = buf_sys_q;
    buf_par_d  = buf_par_q;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_SYNC;
            cnt_d   = CNT_W'(7);
            sys_d   = sys_in;
            par_d   = par_in;
          end
        end
        S_SYNC, S_SYS, S_PAR: begin
          if (accept) begin
            buf_full_d = 1'b1;
            buf_sys_d  = sys_in;
            buf_par_d  = par_in;
          end
          if (cnt_q == '0) begin
            cnt_d = CNT_W'(7);
            case (state_q)
              S_SYNC:  state_d = S_SYS;
              S_SYS:   state_d = S_PAR;
              default: begin
                state_d = S_CHK;
                cnt_d   = '0;
              end
            endcase
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_CHK: begin
          if (buf_full_q) begin
            state_d    = S_SYNC;
            cnt_d      = CNT_W'(7);
            sys_d      = buf_sys_q;
            par_d      = buf_par_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            // Word arriving in the check cycle skips the buffer entirely.
            state_d = S_SYNC;
            cnt_d   = CNT_W'(7);
            sys_d   = sys_in;
            par_d   = par_in;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output next-values, derived from the state being entered.
  always_comb begin
    ser_out_d     = ser_out;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    ready_d       = ~buf_full_d;
    frame_count_d = frame_count;
    if (ena) begin
      ser_valid_d   = (state_d != S_IDLE);
      frame_start_d = (state_d == S_SYNC) && (cnt_d == CNT_W'(7));
      frame_done_d  = (state_d == S_CHK);
      case (state_d)
        S_SYNC:  ser_out_d = SYNC_WORD[cnt_d];
        S_SYS:   ser_out_d = sys_d[cnt_d];
        S_PAR:   ser_out_d = par_d[cnt_d];
        S_CHK:   ser_out_d = ^{sys_d, par_d};
        default: ser_out_d = 1'b0;
      endcase
      if (state_q == S_CHK) begin
        frame_count_d = frame_count + BYTE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_turbo_frame_serializer.sv
// Scoreboard bench for turbo_frame_serializer: a frame-level model queues
// the expected bit stream; a monitor pops one entry per valid output cycle.
module tb_turbo_frame_serializer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FLEN = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       load;
  logic [7:0] sys_in;
  logic [7:0] par_in;
  logic       ready;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic       frame_done;
  logic [7:0] frame_count;

  turbo_frame_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load       (load),
    .sys_in     (sys_in),
    .par_in     (par_in),
    .ready      (ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;      // expected bit
    logic s;      // first bit of frame
    logic d;      // check bit
    logic g;      // must follow the previous frame with no gap
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Frame-level model: bits remaining in the current frame, pending word.
  int         m_rem;
  logic       m_buf;
  logic [7:0] m_bsys, m_bpar;
  logic       m_prev_ena;
  logic [7:0] exp_cnt;
  logic       prev_valid;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void push_frame(input logic [7:0] s, input logic [7:0] p, input logic g);
    logic [FLEN-1:0] bits;
    exp_t e;
    bits = {SYNC, s, p, 1'($countones({s, p}) % 2)};
    for (int i = FLEN - 1; i >= 0; i--) begin
      e.b = bits[i];
      e.s = (i == FLEN - 1);
      e.d = (i == 0);
      e.g = g && (i == FLEN - 1);
      q.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    m_rem      = 0;
    m_buf      = 1'b0;
    m_bsys     = '0;
    m_bpar     = '0;
    m_prev_ena = 1'b0;
  endfunction

  // One cycle of stimulus; the model advances to the state after the next edge.
  task automatic step(input logic l, input logic [7:0] s, input logic [7:0] p, input logic e);
    logic acc;
    @(negedge clk);
    chk("ready", ready, !m_buf);
    load   = l;
    sys_in = s;
    par_in = p;
    ena    = e;
    acc    = l && e && !m_buf;
    if (e) begin
      if (m_rem > 1) begin
        m_rem--;
        if (acc) begin
          m_buf  = 1'b1;
          m_bsys = s;
          m_bpar = p;
        end
      end else if (m_rem == 1) begin
        if (m_buf) begin
          push_frame(m_bsys, m_bpar, m_prev_ena);
          m_buf = 1'b0;
          m_rem = FLEN;
        end else if (acc) begin
          push_frame(s, p, m_prev_ena);
          m_rem = FLEN;
        end else begin
          m_rem = 0;
        end
      end else if (acc) begin
        push_frame(s, p, 1'b0);
        m_rem = FLEN;
      end
    end
    m_prev_ena = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_rem != 0 || m_buf) && n < 200) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      n++;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("idle_valid", ser_valid, 0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_ready", ready, 1);
    model_reset();
    load = 1'b0;
    ena  = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: compare every valid output cycle against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt    = '0;
      prev_valid = 1'b0;
    end else begin
      if (ser_valid) begin
        chk("frame_count", frame_count, exp_cnt);
        if (q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ser_out", ser_out, e.b);
          chk("frame_start", frame_start, e.s);
          chk("frame_done", frame_done, e.d);
          if (e.g) chk("no_gap", prev_valid, 1);
          if (e.d) exp_cnt = exp_cnt + 8'd1;
        end
      end else begin
        chk("idle_start", frame_start, 0);
        chk("idle_done", frame_done, 0);
      end
      prev_valid = ser_valid;
    end
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    load   = 1'b0;
    sys_in = '0;
    par_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_ready", ready, 1);
    chk("init_valid", ser_valid, 0);
    chk("init_count", frame_count, 0);
    rst_n = 1'b1;
    idle(10);

    // Single frame, then check-bit = 1 cases.
    step(1'b1, 8'h3C, 8'h0F, 1'b1);
    drain();
    chk("count_after_one", frame_count, 1);
    step(1'b1, 8'h01, 8'h00, 1'b1);
    drain();
    step(1'b1, 8'hFF, 8'h01, 1'b1);
    drain();

    // Back-to-back with a dropped third load.
    step(1'b1, 8'h12, 8'h34, 1'b1);
    idle(5);
    step(1'b1, 8'hAB, 8'hCD, 1'b1);
    step(1'b1, 8'h77, 8'h88, 1'b1);
    chk("b2b_ready_low", ready, 0);
    drain();
    chk("count_after_b2b", frame_count, 5);

    // Stall during the systematic bits.
    step(1'b1, 8'h3C, 8'h0F, 1'b1);
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("stall_valid", ser_valid, 0);
    drain();

    // Reset in the middle of a frame, then a clean frame.
    step(1'b1, 8'h5A, 8'hC3, 1'b1);
    idle(12);
    reset_now();
    step(1'b1, 8'h96, 8'h69, 1'b1);
    drain();
    chk("count_after_rst", frame_count, 1);

    // Random loads, enables and data.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 7) != 0));
    end
    drain();

    // Continuous loading long enough to wrap frame_count.
    for (int i = 0; i < 260 * FLEN + 30; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    end
    drain();
    chk("final_count", frame_count, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
